// File: rtl/shooter_controller.sv
// Shooter controller: moves the player sprite once per video frame and
// launches bullets into four slots, with a frame-based cooldown between shots.
module shooter_controller #(
  parameter int unsigned X_INIT   = 320,
  parameter int unsigned Y_INIT   = 400,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 639,
  parameter int unsigned Y_MIN    = 0,
  parameter int unsigned Y_MAX    = 479,
  parameter int unsigned STEP     = 2,
  parameter int unsigned COOLDOWN = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [2:0] ShooterMove,
  input  logic       is_shot,
  input  logic [3:0] bullet_done,
  output logic [9:0] ShooterX,
  output logic [9:0] ShooterY,
  output logic       fire_valid,
  output logic [1:0] fire_slot,
  output logic [9:0] fire_x,
  output logic [9:0] fire_y,
  output logic [3:0] slot_busy
);

  // Move codes; any other code means "stand still".
  localparam logic [2:0] MV_UP    = 3'b001;
  localparam logic [2:0] MV_DOWN  = 3'b011;
  localparam logic [2:0] MV_LEFT  = 3'b100;
  localparam logic [2:0] MV_RIGHT = 3'b010;

  // One spare bit so that position +/- STEP can never wrap.
  localparam logic [10:0] STEP_L  = 11'(STEP);
  localparam logic [10:0] X_MIN_L = 11'(X_MIN);
  localparam logic [10:0] X_MAX_L = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_L = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_L = 11'(Y_MAX);
  localparam logic [7:0]  COOL_L  = 8'(COOLDOWN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_COOL = 2'd2
  } fire_state_e;

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [10:0] x_ext, y_ext;
  logic [10:0] x_plus, y_plus;

  fire_state_e state_q;
  logic [7:0]  cnt_q;
  logic        fire_valid_q;
  logic [1:0]  fire_slot_q;
  logic [9:0]  fire_x_q;
  logic [9:0]  fire_y_q;
  logic [3:0]  slot_busy_q;
  logic [3:0]  busy_after_done;
  logic [1:0]  free_slot;
  logic        free_found;

  assign x_ext  = {1'b0, x_q};
  assign y_ext  = {1'b0, y_q};
  assign x_plus = x_ext + STEP_L;
  assign y_plus = y_ext + STEP_L;

  // Clamped next position for the requested move (applied only on a frame tick).
  always_comb begin
    // NOTE: defaults first so every path assigns x_d/y_d and no latch is inferred.
    x_d = x_q;
    y_d = y_q;
    unique case (ShooterMove)
      MV_UP:    y_d = (y_ext < Y_MIN_L + STEP_L) ? Y_MIN_L[9:0] : 10'(y_ext - STEP_L);
      MV_DOWN:  y_d = (y_plus > Y_MAX_L)         ? Y_MAX_L[9:0] : y_plus[9:0];
      MV_LEFT:  x_d = (x_ext < X_MIN_L + STEP_L) ? X_MIN_L[9:0] : 10'(x_ext - STEP_L);
      MV_RIGHT: x_d = (x_plus > X_MAX_L)         ? X_MAX_L[9:0] : x_plus[9:0];
      default:  ;
    endcase
  end

  // Lowest-index free slot, judged on occupancy before this cycle's bullet_done.
  always_comb begin
    free_slot  = 2'd0;
    free_found = ~&slot_busy_q;
    for (int i = 3; i >= 0; i--) begin
      if (!slot_busy_q[i]) free_slot = 2'(i);
    end
  end

  assign busy_after_done = slot_busy_q & ~bullet_done;

  // Position register: steps once per frame tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q <= 10'(X_INIT);
      y_q <= 10'(Y_INIT);
    end else if (frame_tick) begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Fire FSM with registered launch outputs, cooldown counter and slot occupancy.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      fire_valid_q <= 1'b0;
      fire_slot_q  <= 2'd0;
      fire_x_q     <= 10'd0;
      fire_y_q     <= 10'd0;
      slot_busy_q  <= 4'd0;
    end else begin
      fire_valid_q <= 1'b0;
      slot_busy_q  <= busy_after_done;
      unique case (state_q)
        ST_IDLE: begin
          if (frame_tick && is_shot && free_found) begin
            state_q      <= ST_FIRE;
            fire_valid_q <= 1'b1;
            fire_slot_q  <= free_slot;
            fire_x_q     <= x_q;
            fire_y_q     <= y_q;
            // A launch into a slot overrides a same-cycle done on that slot.
            slot_busy_q  <= busy_after_done | (4'b0001 << free_slot);
          end
        end
        ST_FIRE: begin
          state_q <= ST_COOL;
          cnt_q   <= COOL_L;
        end
        ST_COOL: begin
          if (frame_tick) begin
            if (cnt_q <= 8'd1) begin
              state_q <= ST_IDLE;
              cnt_q   <= 8'd0;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ShooterX   = x_q;
  assign ShooterY   = y_q;
  assign fire_valid = fire_valid_q;
  assign fire_slot  = fire_slot_q;
  assign fire_x     = fire_x_q;
  assign fire_y     = fire_y_q;
  assign slot_busy  = slot_busy_q;

endmodule

// File: tb/tb_shooter_controller.sv
// Directed bench for shooter_controller: movement, clamping, auto-fire
// cadence, slot allocation and asynchronous reset.
module tb_shooter_controller;

  localparam logic [2:0] MV_NONE  = 3'b000;
  localparam logic [2:0] MV_UP    = 3'b001;
  localparam logic [2:0] MV_DOWN  = 3'b011;
  localparam logic [2:0] MV_LEFT  = 3'b100;
  localparam logic [2:0] MV_RIGHT = 3'b010;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick;
  logic [2:0] ShooterMove;
  logic       is_shot;
  logic [3:0] bullet_done;

  logic [9:0] ShooterX, ShooterY, fire_x, fire_y;
  logic       fire_valid;
  logic [1:0] fire_slot;
  logic [3:0] slot_busy;

  // Second instance starts near the edges to exercise clamping.
  logic [9:0] ShooterX2, ShooterY2, fire_x2, fire_y2;
  logic       fire_valid2;
  logic [1:0] fire_slot2;
  logic [3:0] slot_busy2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  shooter_controller u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .ShooterMove(ShooterMove), .is_shot(is_shot), .bullet_done(bullet_done),
    .ShooterX(ShooterX), .ShooterY(ShooterY), .fire_valid(fire_valid),
    .fire_slot(fire_slot), .fire_x(fire_x), .fire_y(fire_y), .slot_busy(slot_busy)
  );

  shooter_controller #(.X_INIT(1), .Y_INIT(478)) u_dut_edge (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .ShooterMove(ShooterMove), .is_shot(is_shot), .bullet_done(bullet_done),
    .ShooterX(ShooterX2), .ShooterY(ShooterY2), .fire_valid(fire_valid2),
    .fire_slot(fire_slot2), .fire_x(fire_x2), .fire_y(fire_y2), .slot_busy(slot_busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame tick: inputs applied for exactly one rising edge; returns on the
  // following falling edge so outputs can be sampled right away.
  task automatic tick(input logic [2:0] mv, input logic shot, input logic [3:0] done);
    @(negedge Clk);
    ShooterMove = mv;
    is_shot     = shot;
    bullet_done = done;
    frame_tick  = 1'b1;
    @(negedge Clk);
    frame_tick  = 1'b0;
    bullet_done = 4'b0000;
  endtask

  task automatic pulse_done(input logic [3:0] done);
    @(negedge Clk);
    bullet_done = done;
    @(negedge Clk);
    bullet_done = 4'b0000;
  endtask

  task automatic cool_out();
    for (int i = 0; i < 10; i++) tick(MV_NONE, 1'b0, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n     = 1'b0;
    frame_tick  = 1'b0;
    ShooterMove = MV_NONE;
    is_shot     = 1'b0;
    bullet_done = 4'b0000;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset state
    check("rst_x", ShooterX, 320);
    check("rst_y", ShooterY, 400);
    check("rst_valid", fire_valid, 0);
    check("rst_slot", fire_slot, 0);
    check("rst_fx", fire_x, 0);
    check("rst_fy", fire_y, 0);
    check("rst_busy", slot_busy, 0);
    check("edge_rst_x", ShooterX2, 1);
    check("edge_rst_y", ShooterY2, 478);

    // Move code without a tick does nothing
    ShooterMove = MV_LEFT;
    repeat (3) @(negedge Clk);
    check("no_tick_x", ShooterX, 320);

    // Three left ticks; edge instance clamps at 0
    tick(MV_LEFT, 1'b0, 4'b0000);
    check("left1_x", ShooterX, 318);
    check("edge_left1_x", ShooterX2, 0);
    tick(MV_LEFT, 1'b0, 4'b0000);
    check("left2_x", ShooterX, 316);
    check("edge_left2_x", ShooterX2, 0);
    tick(MV_LEFT, 1'b0, 4'b0000);
    check("left3_x", ShooterX, 314);
    check("left3_y", ShooterY, 400);

    // Down ticks; edge instance clamps at 479
    tick(MV_DOWN, 1'b0, 4'b0000);
    check("down1_y", ShooterY, 402);
    check("edge_down1_y", ShooterY2, 479);
    tick(MV_DOWN, 1'b0, 4'b0000);
    check("down2_y", ShooterY, 404);
    check("edge_down2_y", ShooterY2, 479);

    // Undefined and null codes do not move
    tick(3'b101, 1'b0, 4'b0000);
    tick(3'b110, 1'b0, 4'b0000);
    tick(3'b111, 1'b0, 4'b0000);
    tick(MV_NONE, 1'b0, 4'b0000);
    check("null_x", ShooterX, 314);
    check("null_y", ShooterY, 404);

    tick(MV_RIGHT, 1'b0, 4'b0000);
    check("right_x", ShooterX, 316);
    tick(MV_UP, 1'b0, 4'b0000);
    check("up_y", ShooterY, 402);
    check("idle_busy", slot_busy, 0);

    // Auto-fire with is_shot held: launches at ticks 1, 10, 19, 28
    for (int n = 1; n <= 28; n++) begin
      tick((n == 10) ? MV_RIGHT : MV_NONE, 1'b1, 4'b0000);
      check($sformatf("auto_valid_t%0d", n), fire_valid,
            (n == 1 || n == 10 || n == 19 || n == 28) ? 1 : 0);
      if (n == 1) begin
        check("auto_slot_t1", fire_slot, 0);
        check("auto_fx_t1", fire_x, 316);
        check("auto_fy_t1", fire_y, 402);
        check("auto_busy_t1", slot_busy, 4'b0001);
      end
      if (n == 10) begin
        check("auto_slot_t10", fire_slot, 1);
        check("auto_fx_premove_t10", fire_x, 316);
        check("auto_x_t10", ShooterX, 318);
      end
      if (n == 19) begin
        check("auto_slot_t19", fire_slot, 2);
        check("auto_fx_t19", fire_x, 318);
      end
      if (n == 20) begin
        check("auto_busy_t20", slot_busy, 4'b0111);
        check("auto_slot_hold_t20", fire_slot, 2);
      end
      if (n == 28) begin
        check("auto_slot_t28", fire_slot, 3);
        check("auto_busy_t28", slot_busy, 4'b1111);
      end
    end
    @(negedge Clk);
    check("fire_one_cycle", fire_valid, 0);

    // All slots busy: shot dropped
    cool_out();
    tick(MV_NONE, 1'b1, 4'b0000);
    check("full_valid", fire_valid, 0);
    check("full_busy", slot_busy, 4'b1111);
    pulse_done(4'b0100);
    check("done2_busy", slot_busy, 4'b1011);
    tick(MV_NONE, 1'b1, 4'b0000);
    check("refire_valid", fire_valid, 1);
    check("refire_slot", fire_slot, 2);
    check("refire_busy", slot_busy, 4'b1111);

    // Free all slots, then launch with a same-cycle done on slot 0
    pulse_done(4'b1111);
    check("free_all_busy", slot_busy, 4'b0000);
    cool_out();
    tick(MV_NONE, 1'b1, 4'b0001);
    check("set_wins_valid", fire_valid, 1);
    check("set_wins_slot", fire_slot, 0);
    check("set_wins_busy", slot_busy, 4'b0001);

    // Same-cycle done on busy slot 0 does not free it for this allocation
    cool_out();
    tick(MV_NONE, 1'b1, 4'b0001);
    check("late_free_slot", fire_slot, 1);
    check("late_free_busy", slot_busy, 4'b0010);
    pulse_done(4'b0100);
    check("idle_done_busy", slot_busy, 4'b0010);

    // Reset asserted during cooldown
    cool_out();
    tick(MV_NONE, 1'b1, 4'b0000);
    check("pre_rst_slot", fire_slot, 0);
    check("pre_rst_busy", slot_busy, 4'b0011);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("async_x", ShooterX, 320);
    check("async_y", ShooterY, 400);
    check("async_valid", fire_valid, 0);
    check("async_slot", fire_slot, 0);
    check("async_fx", fire_x, 0);
    check("async_fy", fire_y, 0);
    check("async_busy", slot_busy, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick(MV_NONE, 1'b1, 4'b0000);
    check("post_rst_valid", fire_valid, 1);
    check("post_rst_slot", fire_slot, 0);
    check("post_rst_fx", fire_x, 320);
    check("post_rst_fy", fire_y, 400);
    check("post_rst_busy", slot_busy, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
